// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD-line engine.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_8    = 2'd1,
        RESP_40   = 2'd2,
        RESP_48   = 2'd3
    } resp_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_RECV,
        ST_GAP
    } state_t;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int HALF_SLOW_DEF    = 125;
    localparam int HALF_FAST_DEF    = 2;
    localparam int RESP_TIMEOUT_DEF = 64;
    localparam int GAP_CYCLES_DEF   = 8;

    function automatic logic [5:0] resp_bits(input resp_kind_t k);
        case (k)
            RESP_8:  return 6'd8;
            RESP_40: return 6'd40;
            RESP_48: return 6'd48;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7, one message bit per enable, message MSB first; clear wins over enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb  = i_bit ^ r_crc[6];
    assign o_crc = r_crc;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr)
            r_crc <= '0;
        else if (i_en)
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: generates sd_cclk, sends one CRC7-framed command,
// captures the card response with timeout and reports status.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int CLK_HALF_SLOW = HALF_SLOW_DEF,
    parameter int CLK_HALF_FAST = HALF_FAST_DEF,
    parameter int RESP_TIMEOUT  = RESP_TIMEOUT_DEF,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fast_clk,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_kind,
    output logic        done,
    output logic [47:0] resp_data,
    output logic        resp_timeout,
    output logic        resp_crc_err,
    output logic        sd_cclk,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in
);

    state_t      r_state;
    resp_kind_t  r_kind;
    logic        r_fast;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [5:0]  r_bitcnt;
    logic [39:0] r_tx;
    logic [47:0] r_resp;
    logic        r_cclk, r_oe, r_out, r_ready, r_done, r_tmo, r_crc_err;

    logic [15:0] w_half_m1;
    logic        w_tick, w_rise, w_fall, w_accept, w_drive, w_tx_bit, w_tx_en, w_rx_en;
    logic [2:0]  w_crc_sel;
    logic [6:0]  w_crc_tx, w_crc_rx, w_crc_sh;
    logic [47:0] w_resp_nxt;

    assign w_half_m1 = r_fast ? 16'(CLK_HALF_FAST - 1) : 16'(CLK_HALF_SLOW - 1);
    assign w_tick    = (r_state != ST_IDLE) && (r_div == w_half_m1);
    assign w_rise    = w_tick && !r_cclk;
    assign w_fall    = w_tick && r_cclk;
    assign w_accept  = cmd_valid && r_ready;

    // Bit 0 of the frame goes out on the same fall that ends the preamble
    assign w_drive   = w_fall && ((r_state == ST_PREAMBLE && r_cnt == 16'd7) ||
                                  (r_state == ST_SEND && r_bitcnt != 6'd48));
    assign w_crc_sel = 3'(r_bitcnt - 6'd40);
    assign w_crc_sh  = w_crc_tx << w_crc_sel;
    assign w_tx_bit  = (r_bitcnt < 6'd40) ? r_tx[39] :
                       (r_bitcnt < 6'd47) ? w_crc_sh[6] : 1'b1;
    assign w_tx_en   = w_drive && (r_bitcnt < 6'd40);

    assign w_rx_en    = w_rise && (r_bitcnt < 6'd40) &&
                        ((r_state == ST_WAIT_RESP && !sd_cmd_in) || r_state == ST_RECV);
    assign w_resp_nxt = {r_resp[46:0], sd_cmd_in};

    sd_crc7 u_crc_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_tx_en),
        .i_bit (w_tx_bit),
        .o_crc (w_crc_tx)
    );

    sd_crc7 u_crc_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_rx_en),
        .i_bit (sd_cmd_in),
        .o_crc (w_crc_rx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_kind    <= RESP_NONE;
            r_fast    <= 1'b0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_tx      <= '0;
            r_resp    <= '0;
            r_cclk    <= 1'b0;
            r_oe      <= 1'b0;
            r_out     <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_tmo     <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_div  <= '0;
                r_cclk <= 1'b0;
            end else if (w_tick) begin
                r_div  <= '0;
                r_cclk <= ~r_cclk;
            end else begin
                r_div  <= r_div + 16'd1;
            end

            if (w_drive) begin
                r_out    <= w_tx_bit;
                r_bitcnt <= r_bitcnt + 6'd1;
                if (r_bitcnt < 6'd40)
                    r_tx <= {r_tx[38:0], 1'b0};
            end

            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_kind    <= resp_kind_t'(resp_kind);
                    r_fast    <= fast_clk;
                    r_tx      <= {2'b01, cmd_index, cmd_arg};
                    r_ready   <= 1'b0;
                    r_resp    <= '0;
                    r_tmo     <= 1'b0;
                    r_crc_err <= 1'b0;
                    r_oe      <= 1'b1;
                    r_out     <= 1'b1;
                    r_cnt     <= '0;
                    r_bitcnt  <= '0;
                    r_state   <= ST_PREAMBLE;
                end
                ST_PREAMBLE: if (w_fall) begin
                    if (r_cnt == 16'd7) begin
                        r_cnt   <= '0;
                        r_state <= ST_SEND;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                ST_SEND: if (w_fall && r_bitcnt == 6'd48) begin
                    r_oe     <= 1'b0;
                    r_out    <= 1'b1;
                    r_bitcnt <= '0;
                    r_cnt    <= '0;
                    r_state  <= (r_kind == RESP_NONE) ? ST_GAP : ST_WAIT_RESP;
                end
                // A start bit on the final timeout edge is still accepted
                ST_WAIT_RESP: if (w_rise) begin
                    if (!sd_cmd_in) begin
                        r_resp   <= w_resp_nxt;
                        r_bitcnt <= 6'd1;
                        r_state  <= ST_RECV;
                    end else if (r_cnt == 16'(RESP_TIMEOUT - 1)) begin
                        r_tmo   <= 1'b1;
                        r_resp  <= '1;
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                ST_RECV: if (w_rise) begin
                    r_resp   <= w_resp_nxt;
                    r_bitcnt <= r_bitcnt + 6'd1;
                    if (r_bitcnt + 6'd1 == resp_bits(r_kind)) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                        if (r_kind == RESP_48)
                            r_crc_err <= (w_resp_nxt[7:1] != w_crc_rx) || !sd_cmd_in;
                    end
                end
                ST_GAP: if (w_fall) begin
                    if (r_cnt == 16'(GAP_CYCLES - 1)) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = r_ready;
    assign done         = r_done;
    assign resp_data    = r_resp;
    assign resp_timeout = r_tmo;
    assign resp_crc_err = r_crc_err;
    assign sd_cclk      = r_cclk;
    assign sd_cmd_out   = r_out;
    assign sd_cmd_oe    = r_oe;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: a behavioural card answers on the CMD line,
// expected frames/responses come from polynomial-division CRC7 and plain bit arithmetic.
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fast_clk = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [1:0]  resp_kind = '0;
    logic        done;
    logic [47:0] resp_data;
    logic        resp_timeout, resp_crc_err;
    logic        sd_cclk, sd_cmd_out, sd_cmd_oe, sd_cmd_in;

    typedef struct {
        logic [47:0] data;
        logic        tmo;
        logic        crc;
        logic [55:0] tx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          n_tests = 0, n_fail = 0, n_done = 0, n_push = 0;
    logic [55:0] tx_bits = '0;
    int          tx_n = 0;
    logic        card_en = 1'b0, card_oe = 1'b0, card_bit = 1'b1;
    logic [47:0] card_resp = '0;
    int          card_n = 0, card_delay = 1;

    always #5 clk = ~clk;

    // Pull-up when nobody drives the line
    assign sd_cmd_in = sd_cmd_oe ? sd_cmd_out : (card_oe ? card_bit : 1'b1);

    sd_cmd_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fast_clk     (fast_clk),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .resp_kind    (resp_kind),
        .done         (done),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .resp_crc_err (resp_crc_err),
        .sd_cclk      (sd_cclk),
        .sd_cmd_out   (sd_cmd_out),
        .sd_cmd_oe    (sd_cmd_oe),
        .sd_cmd_in    (sd_cmd_in)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] v;
        v = {d, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic int nbits(input logic [1:0] k);
        return (k == 2'd1) ? 8 : (k == 2'd2) ? 40 : (k == 2'd3) ? 48 : 0;
    endfunction

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] kind,
                         input logic fast, input logic [47:0] rsp, input bit card_on, input bit push);
        exp_t        e;
        int          n;
        logic [47:0] r;
        n = nbits(kind);
        r = rsp;
        if (n < 48) r = r & ((48'd1 << n) - 48'd1);
        if (n > 0)  r[n-1] = 1'b0;
        e.tx = {8'hFF, 2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
        if (kind == 2'd0) begin
            e.data = '0; e.tmo = 1'b0; e.crc = 1'b0;
        end else if (!card_on) begin
            e.data = '1; e.tmo = 1'b1; e.crc = 1'b0;
        end else begin
            e.data = r; e.tmo = 1'b0;
            e.crc  = (kind == 2'd3) && ((crc7_ref(r[47:8]) != r[7:1]) || !r[0]);
        end
        card_resp  = r;
        card_n     = n;
        card_delay = $urandom_range(1, 10);
        card_en    = card_on && (kind != 2'd0);
        if (push) begin
            exp_q.push_back(e);
            n_push++;
        end
        @(negedge clk);
        tx_n = 0; tx_bits = '0;
        cmd_index = idx; cmd_arg = arg; resp_kind = kind; fast_clk = fast; cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk("accept_ready_drop", cmd_ready, 0);
        // Keep requesting with different contents while busy; must be ignored
        cmd_index = 6'($urandom); cmd_arg = $urandom; resp_kind = 2'($urandom);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int g;
        g = 0;
        while (!cmd_ready && g < bound) begin
            @(negedge clk);
            g++;
        end
        chk("idle_within_bound", cmd_ready, 1);
        @(negedge clk);
    endtask

    task automatic measure(output int per);
        logic prev;
        int   edges, g;
        per = 0; edges = 0; g = 0;
        prev = sd_cclk;
        while (edges < 2 && g < 2000) begin
            @(negedge clk);
            g++;
            if (edges == 1) per++;
            if (!prev && sd_cclk) edges++;
            prev = sd_cclk;
        end
    endtask

    // Host frame recorder: what the card sees on its rising edges
    initial forever begin
        @(posedge sd_cclk);
        if (sd_cmd_oe) begin
            tx_bits = {tx_bits[54:0], sd_cmd_out};
            tx_n++;
        end
    end

    // Card: answers after the host releases the line, changing data on sd_cclk falls
    initial forever begin
        @(negedge sd_cmd_oe);
        @(negedge clk);
        if (card_en) begin
            repeat (card_delay) @(negedge sd_cclk);
            for (int i = card_n - 1; i >= 0; i--) begin
                card_oe  = 1'b1;
                card_bit = card_resp[i];
                @(negedge sd_cclk);
            end
            card_oe  = 1'b0;
            card_bit = 1'b1;
        end
    end

    // Monitor: pop and compare on every done pulse
    initial forever begin
        @(negedge clk);
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done with no command outstanding, want none");
            end else begin
                m_e = exp_q.pop_front();
                chk("resp_data", resp_data, m_e.data);
                chk("resp_timeout", resp_timeout, m_e.tmo);
                chk("resp_crc_err", resp_crc_err, m_e.crc);
                chk("tx_bit_count", tx_n, 56);
                chk("tx_frame", tx_bits, m_e.tx);
                chk("ready_with_done", cmd_ready, 1);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish by time limit, want earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] r;
        logic [37:0] body;
        logic [1:0]  k;
        int          per, g, d0;

        repeat (4) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_timeout", resp_timeout, 0);
        chk("rst_crc_err", resp_crc_err, 0);
        chk("rst_cclk", sd_cclk, 0);
        chk("rst_oe", sd_cmd_oe, 0);
        chk("rst_out", sd_cmd_out, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // CMD0 slow; fast_clk raised mid-command must not change the period
        issue(6'd0, 32'd0, 2'd1, 1'b0, 48'h01, 1'b1, 1'b1);
        fast_clk = 1'b1;
        measure(per);
        chk("slow_period", per, 250);
        wait_idle(40000);

        issue(6'd8, 32'h0000_01AA, 2'd2, 1'b1, 48'h01_0000_01AA, 1'b1, 1'b1);
        fast_clk = 1'b0;
        measure(per);
        chk("fast_period", per, 4);
        wait_idle(2000);

        // Silent card
        issue(6'd55, $urandom, 2'd1, 1'b1, 48'h0, 1'b0, 1'b1);
        wait_idle(2000);

        // 48-bit: valid, one CRC bit flipped, end bit cleared
        r    = {$urandom, $urandom};
        body = r[37:0];
        r    = {2'b00, body, crc7_ref({2'b00, body}), 1'b1};
        issue(6'd2, $urandom, 2'd3, 1'b1, r, 1'b1, 1'b1);
        wait_idle(2000);
        issue(6'd2, $urandom, 2'd3, 1'b1, r ^ 48'h4, 1'b1, 1'b1);
        wait_idle(2000);
        issue(6'd9, $urandom, 2'd3, 1'b1, r & ~48'h1, 1'b1, 1'b1);
        wait_idle(2000);

        issue(6'd7, $urandom, 2'd0, 1'b1, 48'h0, 1'b0, 1'b1);
        wait_idle(2000);

        for (int t = 0; t < 10; t++) begin
            k = 2'($urandom_range(0, 3));
            r = {$urandom, $urandom};
            if (k == 2'd3 && $urandom_range(0, 1) == 1) begin
                body = r[37:0];
                r    = {2'b00, body, crc7_ref({2'b00, body}), 1'b1};
            end
            issue(6'($urandom), $urandom, k, 1'b1, r, ($urandom_range(0, 4) != 0), 1'b1);
            wait_idle(2000);
        end

        // Reset in the middle of SEND: aborts without done
        issue(6'd17, $urandom, 2'd1, 1'b1, 48'h0, 1'b0, 1'b0);
        g = 0;
        while (tx_n < 20 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("rst_reached_send", (tx_n >= 20), 1);
        d0 = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_oe", sd_cmd_oe, 0);
        chk("midrst_cclk", sd_cclk, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", n_done, d0);

        issue(6'd0, 32'd0, 2'd1, 1'b1, 48'h01, 1'b1, 1'b1);
        wait_idle(2000);

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_count", n_done, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
